// File: rtl/esp_spi_pkg.sv
// Shared definitions for the ESP32 SPI link: command opcodes, link state and synchroniser depth.
// Imported by the pin front end and the register block.
package esp_spi_pkg;

    localparam int SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [7:0] {
        CMD_OP_01 = 8'h01,
        CMD_OP_10 = 8'h10,
        CMD_OP_11 = 8'h11,
        CMD_OP_20 = 8'h20,
        CMD_OP_21 = 8'h21,
        CMD_OP_22 = 8'h22,
        CMD_OP_23 = 8'h23,
        CMD_OP_24 = 8'h24,
        CMD_OP_25 = 8'h25,
        CMD_OP_30 = 8'h30
    } spi_cmd_e;

    typedef enum logic {
        ST_DESEL = 1'b0,
        ST_SEL   = 1'b1
    } link_state_e;

endpackage

// File: rtl/esp_spi_link_sync_bit.sv
// N-stage flip-flop synchroniser for one asynchronous pin.
// The output is delayed by STAGES clk cycles. RST_VAL is the pin's idle level.
module sync_bit #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (reset) begin
            ff <= {STAGES{RST_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/esp_spi_link.sv
// SPI mode-0 slave front end: synchronises the ESP32 pins, frames messages, and shifts bytes in and out.
// Pin edges are seen SYNC_STAGES+1 cycles late. There is no backpressure: txdata is taken whenever a load occurs.
module esp_spi_link
    import esp_spi_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       esp_ssel_n,
    input  logic       esp_sclk,
    input  logic       esp_mosi,
    output logic       esp_miso,
    output logic       msg_start,
    output logic       msg_end,
    output logic [7:0] rxdata,
    output logic       rxdata_valid,
    input  logic [7:0] txdata,
    output logic       txdata_ack
);

    logic        ssel_sync, sclk_sync, mosi_sync;
    logic        ssel_prev, sclk_prev;
    logic        ssel_fall, ssel_rise, sclk_rise, sclk_fall;
    logic [6:0]  rx_shift;
    logic [7:0]  tx_shift;
    logic [2:0]  bit_cnt;
    logic        rx_done;
    link_state_e state;

    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ssel (
        .clk(clk), .reset(reset), .d(esp_ssel_n), .q(ssel_sync)
    );
    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .d(esp_sclk), .q(sclk_sync)
    );
    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .d(esp_mosi), .q(mosi_sync)
    );

    assign ssel_fall = ssel_prev & ~ssel_sync;
    assign ssel_rise = ~ssel_prev & ssel_sync;
    assign sclk_rise = ~sclk_prev & sclk_sync;
    assign sclk_fall = sclk_prev & ~sclk_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_DESEL;
            ssel_prev    <= 1'b1;
            sclk_prev    <= 1'b0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            bit_cnt      <= '0;
            rx_done      <= 1'b0;
            rxdata       <= '0;
            rxdata_valid <= 1'b0;
            msg_start    <= 1'b0;
            msg_end      <= 1'b0;
            txdata_ack   <= 1'b0;
            esp_miso     <= 1'b0;
        end else begin
            ssel_prev    <= ssel_sync;
            sclk_prev    <= sclk_sync;
            msg_start    <= 1'b0;
            msg_end      <= 1'b0;
            txdata_ack   <= 1'b0;
            rx_done      <= 1'b0;
            rxdata_valid <= rx_done;
            esp_miso     <= (state == ST_SEL) ? tx_shift[7] : 1'b0;

            if (state == ST_DESEL) begin
                if (ssel_fall) begin
                    state      <= ST_SEL;
                    msg_start  <= 1'b1;
                    bit_cnt    <= '0;
                    tx_shift   <= txdata;
                    txdata_ack <= 1'b1;
                end
            end else begin
                // Deselect takes priority; any sclk edge detected alongside it is dropped.
                if (ssel_rise) begin
                    state   <= ST_DESEL;
                    msg_end <= 1'b1;
                    bit_cnt <= '0;
                end else if (sclk_rise) begin
                    rx_shift <= {rx_shift[5:0], mosi_sync};
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rxdata  <= {rx_shift, mosi_sync};
                        rx_done <= 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt == 3'd0) begin
                        tx_shift   <= txdata;
                        txdata_ack <= 1'b1;
                    end else begin
                        tx_shift <= {tx_shift[6:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_esp_spi_link.sv
// Bench for esp_spi_link: drives the ESP32 pins at clk/8 and scoreboards received bytes, MISO bits and framing pulses.
module tb_esp_spi_link;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       esp_ssel_n = 1'b1;
    logic       esp_sclk = 1'b0;
    logic       esp_mosi = 1'b0;
    logic [7:0] txdata = 8'h00;
    logic       esp_miso, msg_start, msg_end, rxdata_valid, txdata_ack;
    logic [7:0] rxdata;

    int checks = 0;
    int failures = 0;
    int n_start = 0, n_end = 0, n_ack = 0, n_valid = 0;
    logic [7:0] rx_q[$];

    esp_spi_link dut (
        .clk(clk), .reset(reset),
        .esp_ssel_n(esp_ssel_n), .esp_sclk(esp_sclk), .esp_mosi(esp_mosi),
        .esp_miso(esp_miso), .msg_start(msg_start), .msg_end(msg_end),
        .rxdata(rxdata), .rxdata_valid(rxdata_valid),
        .txdata(txdata), .txdata_ack(txdata_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (msg_start)  n_start++;
        if (msg_end)    n_end++;
        if (txdata_ack) n_ack++;
        if (rxdata_valid) begin
            n_valid++;
            if (rx_q.size() == 0) chk("rx_unexpected", {31'b0, rxdata_valid}, 32'd0);
            else                  chk("rxdata", {24'b0, rxdata}, {24'b0, rx_q.pop_front()});
        end
    end

    task automatic begin_msg(output int lat);
        lat = -1;
        esp_ssel_n = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (msg_start && lat < 0) lat = k;
        end
    endtask

    task automatic end_msg();
        repeat (4) @(negedge clk);
        esp_ssel_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Shifts nbits of b out on MOSI; optionally checks MISO against tx and records rxdata_valid latency on the last bit.
    task automatic send_byte(input logic [7:0] b, input logic [7:0] tx, input bit ctx,
                             input int nbits, input bit exp_rx, input bit drop_last, output int lat);
        lat = -1;
        if (exp_rx) rx_q.push_back(b);
        for (int i = 0; i < nbits; i++) begin
            esp_mosi = b[7-i];
            repeat (4) @(negedge clk);
            if (ctx) chk($sformatf("miso_%02h_b%0d", tx, i), {31'b0, esp_miso}, {31'b0, tx[7-i]});
            esp_sclk = 1'b1;
            if (drop_last && i == nbits - 1) esp_ssel_n = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                if (i == nbits - 1 && rxdata_valid && lat < 0) lat = k;
            end
            esp_sclk = 1'b0;
        end
    endtask

    initial begin
        int lat, s0, e0, a0, v0;

        // Reset and idle
        repeat (5) @(negedge clk);
        chk("rst_outputs", {23'b0, esp_miso, msg_start, msg_end, rxdata_valid, txdata_ack, rxdata}, 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_pulses", n_start + n_end + n_ack + n_valid, 0);
        chk("idle_outputs", {23'b0, esp_miso, msg_start, msg_end, rxdata_valid, txdata_ack, rxdata}, 32'd0);

        // Two-byte message, txdata changed after the first ack
        txdata = 8'h5A;
        a0 = n_ack;
        begin_msg(lat);
        chk("start_latency", lat, 3);
        txdata = 8'hC3;
        send_byte(8'hA5, 8'h5A, 1'b1, 8, 1'b1, 1'b0, lat);
        chk("rx_latency", lat, 4);
        send_byte(8'h3C, 8'hC3, 1'b1, 8, 1'b1, 1'b0, lat);
        end_msg();
        chk("msg1_start_cnt", n_start, 1);
        chk("msg1_end_cnt", n_end, 1);
        chk("msg1_valid_cnt", n_valid, 2);
        chk("msg1_ack_cnt", n_ack - a0, 3);
        chk("deselect_miso", {31'b0, esp_miso}, 32'd0);

        // Partial byte discarded, next message starts cleanly
        e0 = n_end; v0 = n_valid;
        begin_msg(lat);
        send_byte(8'hFF, 8'h00, 1'b0, 5, 1'b0, 1'b0, lat);
        end_msg();
        chk("partial_end", n_end - e0, 1);
        chk("partial_no_valid", n_valid - v0, 0);
        begin_msg(lat);
        send_byte(8'h96, 8'hC3, 1'b1, 8, 1'b1, 1'b0, lat);
        chk("after_partial_lat", lat, 4);
        end_msg();
        chk("after_partial_rxdata", {24'b0, rxdata}, 32'h96);

        // Deselect coincident with the 8th sclk rise
        e0 = n_end; v0 = n_valid;
        begin_msg(lat);
        send_byte(8'hF0, 8'h00, 1'b0, 8, 1'b0, 1'b1, lat);
        repeat (8) @(negedge clk);
        chk("coinc_end", n_end - e0, 1);
        chk("coinc_no_valid", n_valid - v0, 0);
        chk("coinc_rxdata", {24'b0, rxdata}, 32'h96);

        // Reset mid-byte with ssel held low
        txdata = 8'h11;
        e0 = n_end; s0 = n_start;
        begin_msg(lat);
        send_byte(8'hE7, 8'h00, 1'b0, 3, 1'b0, 1'b0, lat);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("midrst_outputs_%0d", k),
                {23'b0, esp_miso, msg_start, msg_end, rxdata_valid, txdata_ack, rxdata}, 32'd0);
        end
        reset = 1'b0;
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (msg_start && lat < 0) lat = k;
        end
        chk("restart_latency", lat, 3);
        chk("midrst_no_end", n_end - e0, 0);
        send_byte(8'h5C, 8'h11, 1'b1, 8, 1'b1, 1'b0, lat);
        end_msg();
        chk("restart_start_cnt", n_start - s0, 2);
        chk("restart_rxdata", {24'b0, rxdata}, 32'h5C);
        chk("rx_queue_empty", rx_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
